nap_countdown: RTL and testbench

- Parametrised nap countdown engine that replaces the fixed time register and alarm sequencing of the nap machine.
- Loads a BCD HH:MM:SS duration from the manual or shortcut setting path and counts it down at 1 Hz with pause/resume.
- Adds a pre-alarm warning window and a bounded snooze that reloads a fixed duration.
- Drives the lullaby, alarm, light and display paths through its state outputs.

---
 rtl/nap_pkg.sv | 47 ++++
 rtl/bcd_time_dec.sv | 51 +++++
 rtl/nap_countdown.sv | 149 ++++++++++++++
 tb/tb_nap_countdown.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nap_pkg.sv
// nap_pkg
// Shared types and helpers for the nap countdown engine.
//   state_t         : countdown FSM state encoding (IDLE..ALARM)
//   bcd_time_t      : HH:MM:SS as six packed BCD digits, most significant first
//   TIME_ZERO       : 00:00:00
//   bcd_time_valid  : accepts only a real, nonzero time of day (00:00:01..23:59:59)
//   bcd_sub_hour_seconds : MM:SS part of a time expressed as plain binary seconds
package nap_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    ALARM  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;

  // A loadable duration must be a legal clock reading and must not be zero,
  // otherwise the countdown would have nothing to count.
  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic ok;
    ok = (t.h10 <= 4'd2) && (t.h1 <= 4'd9) &&
         (t.m10 <= 4'd5) && (t.m1 <= 4'd9) &&
         (t.s10 <= 4'd5) && (t.s1 <= 4'd9);
    if ((t.h10 == 4'd2) && (t.h1 > 4'd3)) ok = 1'b0;
    if (t == TIME_ZERO) ok = 1'b0;
    return ok;
  endfunction

  // Minutes and seconds folded into binary seconds (0..3599 for legal digits).
  function automatic logic [11:0] bcd_sub_hour_seconds(input bcd_time_t t);
    return 12'(t.m10) * 12'd600 + 12'(t.m1) * 12'd60 +
           12'(t.s10) * 12'd10  + 12'(t.s1);
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// bcd_time_dec
// Combinational one-second decrement of a BCD HH:MM:SS value.
//   cur          in  : current time
//   nxt          out : cur minus one second (00:00:00 stays 00:00:00)
//   is_zero_next out : nxt equals 00:00:00
module bcd_time_dec
  import nap_pkg::*;
(
  input  bcd_time_t cur,
  output bcd_time_t nxt,
  output logic      is_zero_next
);

  // Borrow ripples from seconds up to hours; seconds and minutes tens digits
  // wrap to 5 so each field wraps 00 -> 59. Zero is held rather than wrapped
  // to 23:59:59 so a stray tick can never restart a finished countdown.
  always_comb begin
    nxt = cur;
    if (cur != TIME_ZERO) begin
      if (cur.s1 != 4'd0) begin
        nxt.s1 = cur.s1 - 4'd1;
      end else begin
        nxt.s1 = 4'd9;
        if (cur.s10 != 4'd0) begin
          nxt.s10 = cur.s10 - 4'd1;
        end else begin
          nxt.s10 = 4'd5;
          if (cur.m1 != 4'd0) begin
            nxt.m1 = cur.m1 - 4'd1;
          end else begin
            nxt.m1 = 4'd9;
            if (cur.m10 != 4'd0) begin
              nxt.m10 = cur.m10 - 4'd1;
            end else begin
              nxt.m10 = 4'd5;
              if (cur.h1 != 4'd0) begin
                nxt.h1 = cur.h1 - 4'd1;
              end else begin
                nxt.h1  = 4'd9;
                nxt.h10 = cur.h10 - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  assign is_zero_next = (nxt == TIME_ZERO);

endmodule

// File: rtl/nap_countdown.sv
// nap_countdown
// Nap timer: loads a BCD HH:MM:SS duration, counts it down once per second,
// supports pause/resume, raises a warning near the end, and offers a bounded
// snooze that reloads 00:SNOOZE_MIN:00.
//   clock        in  : system clock
//   reset        in  : asynchronous, active-low reset
//   load         in  : pulse, capture load_time (IDLE/LOADED only)
//   load_time    in  : BCD {H10,H1,M10,M1,S10,S1}
//   start        in  : pulse, begin or resume countdown
//   pause        in  : pulse, freeze countdown
//   snooze       in  : pulse, reload snooze time from ALARM
//   stop         in  : pulse, abort/acknowledge, back to IDLE
//   cur_time     out : remaining time, BCD
//   state_o      out : encoded state
//   running      out : high in RUN
//   warn         out : high in RUN/PAUSE when remaining time <= WARN_SEC
//   alarm_on     out : high in ALARM
//   done_pulse   out : one cycle on entry to ALARM
//   load_err     out : one cycle when a load is rejected
//   snooze_left  out : snoozes remaining for this alarm
module nap_countdown
  import nap_pkg::*;
#(
  parameter int TICK_DIV   = 1000000,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int WARN_SEC   = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        start,
  input  logic        pause,
  input  logic        snooze,
  input  logic        stop,
  output logic [23:0] cur_time,
  output logic [2:0]  state_o,
  output logic        running,
  output logic        warn,
  output logic        alarm_on,
  output logic        done_pulse,
  output logic        load_err,
  output logic [3:0]  snooze_left
);

  localparam int             PW          = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PS_LAST     = PW'(TICK_DIV - 1);
  localparam logic [3:0]     SNOOZE_INIT = 4'(MAX_SNOOZE);
  localparam logic [11:0]    WARN_LIMIT  = 12'(WARN_SEC);
  localparam bcd_time_t      SNOOZE_TIME = '{h10: 4'd0, h1: 4'd0,
                                             m10: 4'(SNOOZE_MIN / 10),
                                             m1:  4'(SNOOZE_MIN % 10),
                                             s10: 4'd0, s1: 4'd0};

  state_t         state;
  bcd_time_t      time_q;
  bcd_time_t      time_dec;
  logic           dec_zero;
  logic [PW-1:0]  prescale;
  logic [3:0]     snooze_cnt;
  logic [11:0]    sub_hour_sec;

  bcd_time_dec u_dec (
    .cur          (time_q),
    .nxt          (time_dec),
    .is_zero_next (dec_zero)
  );

  // Single FSM. Commands are checked in priority order stop > snooze > pause
  // > start > load, each guarded by the states where it is meaningful, so an
  // illegal high-priority command falls through to the next one. Ticking only
  // happens in RUN when no legal command acted, which is how stop (or pause)
  // wins over a decrement landing in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      time_q     <= TIME_ZERO;
      prescale   <= '0;
      snooze_cnt <= SNOOZE_INIT;
      running    <= 1'b0;
      alarm_on   <= 1'b0;
      done_pulse <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      load_err   <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        time_q     <= TIME_ZERO;
        prescale   <= '0;
        snooze_cnt <= SNOOZE_INIT;
        running    <= 1'b0;
        alarm_on   <= 1'b0;
      end else if (snooze && (state == ALARM)) begin
        if (snooze_cnt != 4'd0) begin
          state      <= RUN;
          time_q     <= SNOOZE_TIME;
          prescale   <= '0;
          snooze_cnt <= snooze_cnt - 4'd1;
          running    <= 1'b1;
          alarm_on   <= 1'b0;
        end
      end else if (pause && (state == RUN)) begin
        state   <= PAUSE;
        running <= 1'b0;
      end else if (start && ((state == LOADED) || (state == PAUSE))) begin
        state    <= RUN;
        prescale <= '0;
        running  <= 1'b1;
      end else if (load && ((state == IDLE) || (state == LOADED))) begin
        if (bcd_time_valid(load_time)) begin
          state      <= LOADED;
          time_q     <= load_time;
          snooze_cnt <= SNOOZE_INIT;
        end else begin
          load_err <= 1'b1;
        end
      end else if (state == RUN) begin
        if (prescale == PS_LAST) begin
          prescale <= '0;
          time_q   <= time_dec;
          if (dec_zero) begin
            state      <= ALARM;
            running    <= 1'b0;
            alarm_on   <= 1'b1;
            done_pulse <= 1'b1;
          end
        end else begin
          prescale <= prescale + 1'b1;
        end
      end
    end
  end

  // Warning only needs the sub-hour part; any nonzero hour digit means the
  // remaining time is far above any legal WARN_SEC.
  always_comb begin
    sub_hour_sec = bcd_sub_hour_seconds(time_q);
    warn = ((state == RUN) || (state == PAUSE)) && (WARN_LIMIT != 12'd0) &&
           (time_q.h10 == 4'd0) && (time_q.h1 == 4'd0) &&
           (sub_hour_sec <= WARN_LIMIT);
  end

  assign cur_time    = time_q;
  assign state_o     = state;
  assign snooze_left = snooze_cnt;

endmodule

// File: tb/tb_nap_countdown.sv
// tb_nap_countdown
// Directed scoreboard bench for nap_countdown with a fast tick (TICK_DIV=4),
// a one-minute single snooze and a 30 second warning window. Inputs are driven
// and outputs sampled on the falling clock edge; the DUT acts on rising edges.
module tb_nap_countdown;

  localparam int TICK_DIV   = 4;
  localparam int SNOOZE_MIN = 1;
  localparam int MAX_SNOOZE = 1;
  localparam int WARN_SEC   = 30;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADED = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;

  localparam int C_LOAD   = 0;
  localparam int C_START  = 1;
  localparam int C_PAUSE  = 2;
  localparam int C_SNOOZE = 3;
  localparam int C_STOP   = 4;

  logic        clock;
  logic        reset;
  logic        load;
  logic [23:0] load_time;
  logic        start;
  logic        pause;
  logic        snooze;
  logic        stop;
  logic [23:0] cur_time;
  logic [2:0]  state_o;
  logic        running;
  logic        warn;
  logic        alarm_on;
  logic        done_pulse;
  logic        load_err;
  logic [3:0]  snooze_left;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  nap_countdown #(
    .TICK_DIV   (TICK_DIV),
    .SNOOZE_MIN (SNOOZE_MIN),
    .MAX_SNOOZE (MAX_SNOOZE),
    .WARN_SEC   (WARN_SEC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_time   (load_time),
    .start       (start),
    .pause       (pause),
    .snooze      (snooze),
    .stop        (stop),
    .cur_time    (cur_time),
    .state_o     (state_o),
    .running     (running),
    .warn        (warn),
    .alarm_on    (alarm_on),
    .done_pulse  (done_pulse),
    .load_err    (load_err),
    .snooze_left (snooze_left)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net in case the run wedges somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Independent warning model: only under one hour, and MM:SS in seconds
  // within the window, and only while counting or paused.
  function automatic logic warn_model(input logic [23:0] t, input bit active);
    int secs;
    secs = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    return active && (t[23:16] == 8'h00) && (secs <= WARN_SEC);
  endfunction

  // Record what the DUT should show at the next sample point.
  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against an observed output.
  task automatic check_output(input logic [31:0] obs);
    exp_t e;
    assert_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("[TB] FAIL scoreboard_underflow observed=%0h expected=entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        fail_cnt++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One-cycle command pulse, launched and retired on falling edges.
  task automatic apply_stimulus(input int cmd, input logic [23:0] t);
    load_time = t;
    case (cmd)
      C_LOAD:   load   = 1'b1;
      C_START:  start  = 1'b1;
      C_PAUSE:  pause  = 1'b1;
      C_SNOOZE: snooze = 1'b1;
      C_STOP:   stop   = 1'b1;
      default:  ;
    endcase
    @(negedge clock);
    load   = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    snooze = 1'b0;
    stop   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Directed sequence following the intended use of the timer.
  initial begin
    logic [23:0] bad_times [3];
    bad_times[0] = 24'h009900;
    bad_times[1] = 24'h240000;
    bad_times[2] = 24'h000000;

    reset = 1'b0; load = 1'b0; load_time = '0;
    start = 1'b0; pause = 1'b0; snooze = 1'b0; stop = 1'b0;

    // Reset values while reset is held.
    wait_cycles(2);
    push_exp("rst_state", 32'(S_IDLE));
    push_exp("rst_time", 32'h0);
    push_exp("rst_snooze_left", 32'(MAX_SNOOZE));
    push_exp("rst_running", 32'h0);
    push_exp("rst_alarm", 32'h0);
    push_exp("rst_done", 32'h0);
    push_exp("rst_err", 32'h0);
    push_exp("rst_warn", 32'h0);
    check_output(32'(state_o));
    check_output(32'(cur_time));
    check_output(32'(snooze_left));
    check_output(32'(running));
    check_output(32'(alarm_on));
    check_output(32'(done_pulse));
    check_output(32'(load_err));
    check_output(32'(warn));
    reset = 1'b1;
    wait_cycles(1);
    $display("[TB] reset checks done");

    // Three second countdown into ALARM.
    push_exp("t1_load_state", 32'(S_LOADED));
    push_exp("t1_load_time", 32'h000003);
    apply_stimulus(C_LOAD, 24'h000003);
    check_output(32'(state_o));
    check_output(32'(cur_time));
    push_exp("t1_run_state", 32'(S_RUN));
    push_exp("t1_running", 32'h1);
    push_exp("t1_warn", 32'(warn_model(24'h000003, 1'b1)));
    apply_stimulus(C_START, 24'h0);
    check_output(32'(state_o));
    check_output(32'(running));
    check_output(32'(warn));
    wait_cycles(3);
    push_exp("t1_hold_before_tick", 32'h000003);
    check_output(32'(cur_time));
    wait_cycles(1);
    push_exp("t1_tick1", 32'h000002);
    check_output(32'(cur_time));
    wait_cycles(4);
    push_exp("t1_tick2", 32'h000001);
    check_output(32'(cur_time));
    wait_cycles(3);
    push_exp("t1_no_early_done", 32'h0);
    check_output(32'(done_pulse));
    wait_cycles(1);
    push_exp("t1_zero", 32'h000000);
    push_exp("t1_alarm_state", 32'(S_ALARM));
    push_exp("t1_done", 32'h1);
    push_exp("t1_alarm_on", 32'h1);
    push_exp("t1_alarm_warn", 32'h0);
    check_output(32'(cur_time));
    check_output(32'(state_o));
    check_output(32'(done_pulse));
    check_output(32'(alarm_on));
    check_output(32'(warn));
    wait_cycles(1);
    push_exp("t1_done_single", 32'h0);
    push_exp("t1_alarm_hold", 32'(S_ALARM));
    check_output(32'(done_pulse));
    check_output(32'(state_o));

    // Snooze reloads one minute, warning appears at 30 seconds left.
    push_exp("sn_state", 32'(S_RUN));
    push_exp("sn_time", 32'h000100);
    push_exp("sn_left", 32'h0);
    push_exp("sn_warn", 32'(warn_model(24'h000100, 1'b1)));
    apply_stimulus(C_SNOOZE, 24'h0);
    check_output(32'(state_o));
    check_output(32'(cur_time));
    check_output(32'(snooze_left));
    check_output(32'(warn));
    wait_cycles(119);
    push_exp("sn_time31", 32'h000031);
    push_exp("sn_warn31", 32'(warn_model(24'h000031, 1'b1)));
    check_output(32'(cur_time));
    check_output(32'(warn));
    wait_cycles(1);
    push_exp("sn_time30", 32'h000030);
    push_exp("sn_warn30", 32'(warn_model(24'h000030, 1'b1)));
    check_output(32'(cur_time));
    check_output(32'(warn));
    wait_cycles(120);
    push_exp("sn_alarm_state", 32'(S_ALARM));
    push_exp("sn_alarm_done", 32'h1);
    check_output(32'(state_o));
    check_output(32'(done_pulse));
    push_exp("sn_ignored_state", 32'(S_ALARM));
    push_exp("sn_ignored_left", 32'h0);
    push_exp("sn_ignored_time", 32'h0);
    apply_stimulus(C_SNOOZE, 24'h0);
    check_output(32'(state_o));
    check_output(32'(snooze_left));
    check_output(32'(cur_time));
    push_exp("sn_stop_state", 32'(S_IDLE));
    push_exp("sn_stop_left", 32'(MAX_SNOOZE));
    push_exp("sn_stop_alarm", 32'h0);
    apply_stimulus(C_STOP, 24'h0);
    check_output(32'(state_o));
    check_output(32'(snooze_left));
    check_output(32'(alarm_on));
    $display("[TB] countdown and snooze checks done");

    // Full borrow chain across hours, minutes and seconds.
    push_exp("br_state", 32'(S_LOADED));
    apply_stimulus(C_LOAD, 24'h010000);
    check_output(32'(state_o));
    apply_stimulus(C_START, 24'h0);
    wait_cycles(3);
    push_exp("br_hold", 32'h010000);
    check_output(32'(cur_time));
    wait_cycles(1);
    push_exp("br_borrow", 32'h005959);
    check_output(32'(cur_time));
    apply_stimulus(C_STOP, 24'h0);

    // Rejected loads in IDLE, then a boundary-valid load, then a reject in LOADED.
    foreach (bad_times[i]) begin
      push_exp($sformatf("bad%0d_err", i), 32'h1);
      push_exp($sformatf("bad%0d_state", i), 32'(S_IDLE));
      push_exp($sformatf("bad%0d_time", i), 32'h0);
      apply_stimulus(C_LOAD, bad_times[i]);
      check_output(32'(load_err));
      check_output(32'(state_o));
      check_output(32'(cur_time));
      wait_cycles(1);
      push_exp($sformatf("bad%0d_err_clear", i), 32'h0);
      check_output(32'(load_err));
    end
    push_exp("max_state", 32'(S_LOADED));
    push_exp("max_time", 32'h235959);
    push_exp("max_err", 32'h0);
    apply_stimulus(C_LOAD, 24'h235959);
    check_output(32'(state_o));
    check_output(32'(cur_time));
    check_output(32'(load_err));
    push_exp("ld_bad_err", 32'h1);
    push_exp("ld_bad_state", 32'(S_LOADED));
    push_exp("ld_bad_time", 32'h235959);
    apply_stimulus(C_LOAD, 24'h006000);
    check_output(32'(load_err));
    check_output(32'(state_o));
    check_output(32'(cur_time));
    apply_stimulus(C_STOP, 24'h0);
    $display("[TB] load validation checks done");

    // Pause after two ticks, hold for 20 cycles, resume with a fresh prescaler.
    apply_stimulus(C_LOAD, 24'h000010);
    apply_stimulus(C_START, 24'h0);
    wait_cycles(8);
    push_exp("pa_two_ticks", 32'h000008);
    check_output(32'(cur_time));
    push_exp("pa_state", 32'(S_PAUSE));
    push_exp("pa_running", 32'h0);
    push_exp("pa_warn", 32'(warn_model(24'h000008, 1'b1)));
    apply_stimulus(C_PAUSE, 24'h0);
    check_output(32'(state_o));
    check_output(32'(running));
    check_output(32'(warn));
    wait_cycles(20);
    push_exp("pa_held_time", 32'h000008);
    push_exp("pa_held_state", 32'(S_PAUSE));
    check_output(32'(cur_time));
    check_output(32'(state_o));
    apply_stimulus(C_START, 24'h0);
    wait_cycles(3);
    push_exp("pa_resume_hold", 32'h000008);
    check_output(32'(cur_time));
    wait_cycles(1);
    push_exp("pa_resume_tick", 32'h000007);
    push_exp("pa_resume_running", 32'h1);
    check_output(32'(cur_time));
    check_output(32'(running));
    apply_stimulus(C_STOP, 24'h0);

    // Stop lands on the same edge as the decrement to zero.
    apply_stimulus(C_LOAD, 24'h000001);
    apply_stimulus(C_START, 24'h0);
    wait_cycles(3);
    push_exp("race_state", 32'(S_IDLE));
    push_exp("race_done", 32'h0);
    push_exp("race_alarm", 32'h0);
    push_exp("race_time", 32'h0);
    apply_stimulus(C_STOP, 24'h0);
    check_output(32'(state_o));
    check_output(32'(done_pulse));
    check_output(32'(alarm_on));
    check_output(32'(cur_time));
    wait_cycles(1);
    push_exp("race_state_after", 32'(S_IDLE));
    push_exp("race_done_after", 32'h0);
    check_output(32'(state_o));
    check_output(32'(done_pulse));
    $display("[TB] pause and stop race checks done");

    // Asynchronous reset in the middle of RUN, checked before the next edge.
    apply_stimulus(C_LOAD, 24'h000010);
    apply_stimulus(C_START, 24'h0);
    wait_cycles(5);
    #2;
    reset = 1'b0;
    #1;
    push_exp("ar_state", 32'(S_IDLE));
    push_exp("ar_time", 32'h0);
    push_exp("ar_running", 32'h0);
    push_exp("ar_warn", 32'h0);
    push_exp("ar_left", 32'(MAX_SNOOZE));
    push_exp("ar_alarm", 32'h0);
    check_output(32'(state_o));
    check_output(32'(cur_time));
    check_output(32'(running));
    check_output(32'(warn));
    check_output(32'(snooze_left));
    check_output(32'(alarm_on));
    @(negedge clock);
    reset = 1'b1;
    wait_cycles(1);

    // Every expectation pushed must have been consumed.
    assert_cnt++;
    assert (exp_q.size() == 0) else begin
      fail_cnt++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
